// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder for a bank of N_REGS 32-bit registers.
// Write address and data are held independently and commit together; reads complete in one cycle.
module axil_reg_slave #(
    parameter int N_REGS = 8,
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    s_awaddr,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [31:0]          s_wdata,
    input  logic [3:0]           s_wstrb,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    output logic [1:0]           s_bresp,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    input  logic [ADDR_W-1:0]    s_araddr,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    output logic [31:0]          s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic [N_REGS*32-1:0] regs_o
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W:0] N_REGS_W = (IDX_W + 1)'(N_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0]      regs_q [N_REGS];
    logic [31:0]      regs_d [N_REGS];
    logic             aw_held_q, aw_held_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic             w_held_q, w_held_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [IDX_W-1:0] ar_idx;
    logic [31:0]      rd_sel;
    logic             commit;
    logic             unused_addr_lsb;

    assign ar_idx          = s_araddr[ADDR_W-1:2];
    assign unused_addr_lsb = ^{s_awaddr[1:0], s_araddr[1:0]};
    assign commit          = aw_held_q && w_held_q && !bvalid_q;

    assign s_awready = !aw_held_q;
    assign s_wready  = !w_held_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = !rvalid_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;

    // Read mux samples regs_q, so a same-edge write commit is not visible to the read.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) rd_sel = regs_q[i];
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        regs_d    = regs_q;
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        if (s_awvalid && !aw_held_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_awaddr[ADDR_W-1:2];
        end
        if (s_wvalid && !w_held_q) begin
            w_held_d = 1'b1;
            w_data_d = s_wdata;
            w_strb_d = s_wstrb;
        end
        if (bvalid_q && s_bready) begin
            bvalid_d = 1'b0;
            bresp_d  = RESP_OKAY;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = ({1'b0, aw_idx_q} < N_REGS_W) ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < N_REGS; i++) begin
                if (aw_idx_q == IDX_W'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb_q[b]) regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end

        if (rvalid_q && s_rready) rvalid_d = 1'b0;
        if (s_arvalid && !rvalid_q) begin
            rvalid_d = 1'b1;
            if ({1'b0, ar_idx} < N_REGS_W) begin
                rdata_d = rd_sel;
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register bank is software-visible state and must read 0 after reset, so it is reset like any flop.
            for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < N_REGS; i++) regs_o[32*i +: 32] = regs_q[i];
    end

endmodule
